// File: rtl/cordic_share_arbiter.sv
// Round-robin sharing of one fixed-latency pipelined CORDIC core among N_REQ
// requesters. A tag pipeline as deep as the core routes each result back to
// the requester that issued it; each requester holds one result register.

// Per-requester state: IDLE -> BUSY (issued) -> DONE (result held) -> IDLE.
module cordic_share_lane #(
  parameter int OP_W = 60
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue,
  input  logic            tag_hit,
  input  logic [OP_W-1:0] core_results,
  input  logic            rsp_ready,
  output logic            idle,
  output logic            rsp_valid,
  output logic [OP_W-1:0] rsp_result
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;

  // State register.
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_nxt;

  // Next-state: a DONE lane only returns to IDLE after its consumer takes the result.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue)     state_nxt = BUSY;
      BUSY:    if (tag_hit)   state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Capture the core output when this lane's tag exits; held stale otherwise.
  always_ff @(posedge clk or negedge reset)
    if (!reset)                         rsp_result <= '0;
    else if (tag_hit && state == BUSY)  rsp_result <= core_results;

  assign idle      = (state == IDLE);
  assign rsp_valid = (state == DONE);
endmodule

module cordic_share_arbiter #(
  parameter int N_REQ   = 4,
  parameter int IDX_W   = 2,
  parameter int OP_W    = 60,
  parameter int LATENCY = 12,
  parameter int CNT_W   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*OP_W-1:0] req_operand,
  output logic [N_REQ-1:0]      rsp_valid,
  input  logic [N_REQ-1:0]      rsp_ready,
  output logic [N_REQ*OP_W-1:0] rsp_result,
  output logic [OP_W-1:0]       core_operand,
  input  logic [OP_W-1:0]       core_results,
  output logic                  busy,
  output logic [CNT_W-1:0]      inflight
);
  logic [N_REQ-1:0]              idle, elig, grant, tag_hit;
  logic [IDX_W-1:0]              ptr, gidx;
  logic                          gvalid, issue_any, tag_exit;
  logic [LATENCY:0]              vld_pipe;
  logic [LATENCY:0][IDX_W-1:0]   idx_pipe;

  // Round-robin pick: first eligible index at or after ptr, wrapping.
  // Scanning downwards lets the lowest offset win without an early exit.
  always_comb begin
    int j;
    elig   = req_valid & idle;
    gvalid = 1'b0;
    gidx   = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N_REQ;
      if (elig[j]) begin
        gvalid = 1'b1;
        gidx   = IDX_W'(j);
      end
    end
    grant = gvalid ? (N_REQ'(1) << gidx) : '0;
  end

  // Grants are forced off while reset is asserted so no handshake leaks through.
  assign req_ready = grant & {N_REQ{reset}};
  assign issue_any = gvalid & reset;

  // Pointer moves past the granted index; unchanged when nothing issues.
  always_ff @(posedge clk or negedge reset)
    if (!reset)         ptr <= '0;
    else if (issue_any) ptr <= (gidx == IDX_W'(N_REQ - 1)) ? '0 : gidx + IDX_W'(1);

  // Operand register feeding the core; zero on idle cycles.
  always_ff @(posedge clk or negedge reset)
    if (!reset) core_operand <= '0;
    else        core_operand <= issue_any ? req_operand[gidx*OP_W +: OP_W] : '0;

  // Tag shift register: stage LATENCY lines up with the matching core output.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[LATENCY-1:0], issue_any};
      idx_pipe <= {idx_pipe[LATENCY-1:0], gidx};
    end

  assign tag_exit = vld_pipe[LATENCY];
  assign tag_hit  = tag_exit ? (N_REQ'(1) << idx_pipe[LATENCY]) : '0;

  // In-flight counter: simultaneous issue and exit cancel out.
  always_ff @(posedge clk or negedge reset)
    if (!reset) inflight <= '0;
    else case ({issue_any, tag_exit})
      2'b10:   inflight <= inflight + CNT_W'(1);
      2'b01:   inflight <= inflight - CNT_W'(1);
      default: inflight <= inflight;
    endcase

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    cordic_share_lane #(.OP_W(OP_W)) u_lane (
      .clk          (clk),
      .reset        (reset),
      .issue        (req_ready[i]),
      .tag_hit      (tag_hit[i]),
      .core_results (core_results),
      .rsp_ready    (rsp_ready[i]),
      .idle         (idle[i]),
      .rsp_valid    (rsp_valid[i]),
      .rsp_result   (rsp_result[i*OP_W +: OP_W])
    );
  end

  assign busy = |(~idle);
endmodule

// File: tb/tb_cordic_share_arbiter.sv
// Bench for cordic_share_arbiter with a delay-line stub core (result = operand ^ 'h5A5).
module tb_cordic_share_arbiter;
  localparam int N_REQ = 4, IDX_W = 2, OP_W = 60, LATENCY = 12, CNT_W = 3;

  logic                          clk = 1'b0;
  logic                          reset = 1'b0;
  logic [N_REQ-1:0]              req_valid = '0;
  logic [N_REQ-1:0]              req_ready;
  logic [N_REQ-1:0][OP_W-1:0]    req_operand = '0;
  logic [N_REQ-1:0]              rsp_valid;
  logic [N_REQ-1:0]              rsp_ready = '0;
  logic [N_REQ-1:0][OP_W-1:0]    rsp_result;
  logic [OP_W-1:0]               core_operand, core_results;
  logic                          busy;
  logic [CNT_W-1:0]              inflight;

  int n_chk = 0, n_err = 0;

  cordic_share_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W), .OP_W(OP_W), .LATENCY(LATENCY), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_operand(req_operand), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .core_operand(core_operand), .core_results(core_results),
    .busy(busy), .inflight(inflight)
  );

  always #5 clk = ~clk;

  // Stub core: LATENCY-stage delay line.
  logic [LATENCY-1:0][OP_W-1:0] dl;
  always_ff @(posedge clk or negedge reset)
    if (!reset) dl <= '0;
    else        dl <= {dl[LATENCY-2:0], core_operand};
  assign core_results = dl[LATENCY-1] ^ OP_W'('h5A5);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    reset = 1'b0; tick(); tick(); reset = 1'b1;
  endtask

  task automatic drain(input int n);
    req_valid = '0; rsp_ready = '1;
    repeat (n) tick();
    #1;
    chk("drain_busy", busy, 0);
    chk("drain_inflight", inflight, 0);
  endtask

  // Scoreboard monitor: records issues and checks each consumed result.
  logic [N_REQ-1:0]           outst = '0, iss_seen = '0;
  logic [N_REQ-1:0][OP_W-1:0] exp_op = '0;
  int comp [N_REQ];
  int n_iss = 0, n_cmp = 0;
  initial for (int i = 0; i < N_REQ; i++) comp[i] = 0;

  always @(negedge clk) begin
    if (!reset) begin
      outst    = '0;
      iss_seen = '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        iss_seen[i] = req_valid[i] & req_ready[i];
        if (rsp_valid[i]) chk("spurious_rsp", outst[i], 1);
        if (rsp_valid[i] && rsp_ready[i]) begin
          chk("route_value", rsp_result[i], exp_op[i] ^ OP_W'('h5A5));
          outst[i] = 1'b0;
          n_cmp++;
          comp[i]++;
        end
        if (iss_seen[i]) begin
          chk("dup_issue", outst[i], 0);
          outst[i]  = 1'b1;
          exp_op[i] = req_operand[i];
          n_iss++;
        end
      end
    end
  end

  initial begin
    logic [N_REQ-1:0] er, ev, sticky;
    int base [N_REQ];
    int seq;

    // Reset state, with requests present to confirm grants are suppressed.
    req_valid = '1;
    tick(); tick(); #1;
    chk("rst_core_operand", core_operand, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_inflight", inflight, 0);
    tick();
    reset = 1'b1; req_valid = '0;
    tick(); tick();

    // 1: single op on requester 0.
    req_valid = 4'b0001; req_operand[0] = OP_W'('h123);
    #1 chk("t1_grant", req_ready, 4'b0001);
    tick(); req_valid = '0;
    #1;
    chk("t1_inflight_first", inflight, 1);
    chk("t1_core_operand", core_operand, 'h123);
    chk("t1_busy", busy, 1);
    repeat (12) tick();
    #1;
    chk("t1_inflight_last", inflight, 1);
    chk("t1_rsp_early", rsp_valid, 0);
    tick(); #1;
    chk("t1_rsp_valid", rsp_valid, 4'b0001);
    chk("t1_rsp_result", rsp_result[0], 'h123 ^ 'h5A5);
    chk("t1_inflight_done", inflight, 0);
    rsp_ready = 4'b0001;
    tick(); #1;
    chk("t1_consumed", rsp_valid, 0);
    chk("t1_idle", busy, 0);
    rsp_ready = '0;

    // 2: all requesters, back-to-back grants and in-order returns.
    do_reset();
    for (int i = 0; i < N_REQ; i++) req_operand[i] = OP_W'('h100 + i);
    req_valid = '1; rsp_ready = '1;
    for (int c = 0; c < 20; c++) begin
      #1;
      er = (c < 4) ? 4'(1 << c) : (c >= 15 && c <= 18) ? 4'(1 << (c - 15)) : 4'b0;
      ev = (c >= 14 && c <= 17) ? 4'(1 << (c - 14)) : 4'b0;
      chk($sformatf("t2_grant_c%0d", c), req_ready, er);
      chk($sformatf("t2_rspv_c%0d", c), rsp_valid, ev);
      if (c >= 14 && c <= 17)
        chk($sformatf("t2_result_%0d", c - 14), rsp_result[c-14], ('h100 + c - 14) ^ 'h5A5);
      tick();
    end
    drain(40);

    // 3: requesters 0 and 2 alternate; 2 wins when the pointer is past 0.
    do_reset();
    req_operand[0] = OP_W'('hA0); req_operand[2] = OP_W'('hA2);
    req_valid = 4'b0001; rsp_ready = '1;
    for (int c = 0; c < 32; c++) begin
      if (c == 15) req_valid = 4'b0101;
      #1;
      case (c)
        0, 16, 31: er = 4'b0001;
        15, 30:    er = 4'b0100;
        default:   er = 4'b0000;
      endcase
      chk($sformatf("t3_grant_c%0d", c), req_ready, er);
      tick();
    end
    drain(40);

    // 4: backpressure on requester 1 only.
    do_reset();
    for (int i = 0; i < N_REQ; i++) req_operand[i] = OP_W'('hB0 + i);
    req_valid = '1; rsp_ready = 4'b1101;
    repeat (15) tick();
    for (int i = 0; i < N_REQ; i++) base[i] = comp[i];
    for (int c = 0; c < 50; c++) begin
      #1;
      chk("t4_rspv1_held", rsp_valid[1], 1);
      chk("t4_result1_held", rsp_result[1], 'hB1 ^ 'h5A5);
      chk("t4_ready1_low", req_ready[1], 0);
      tick();
    end
    chk("t4_req0_progress", (comp[0] - base[0]) >= 2, 1);
    chk("t4_req2_progress", (comp[2] - base[2]) >= 2, 1);
    chk("t4_req3_progress", (comp[3] - base[3]) >= 2, 1);
    rsp_ready = '1;
    tick(); #1;
    chk("t4_rspv1_cleared", rsp_valid[1], 0);
    drain(40);

    // 5: reset with three ops in flight.
    do_reset();
    req_valid = 4'b0111; rsp_ready = '1;
    repeat (5) tick();
    reset = 1'b0;
    #1;
    chk("t5_core_operand", core_operand, 0);
    chk("t5_rsp_valid", rsp_valid, 0);
    chk("t5_rsp_result", rsp_result, 0);
    chk("t5_req_ready", req_ready, 0);
    chk("t5_busy", busy, 0);
    chk("t5_inflight", inflight, 0);
    tick(); tick();
    reset = 1'b1; req_valid = '0;
    sticky = '0;
    repeat (20) begin
      #1 sticky |= rsp_valid;
      tick();
    end
    chk("t5_no_stale_rsp", sticky, 0);
    req_valid = 4'b1010;
    #1 chk("t5_first_grant", req_ready, 4'b0010);
    tick();
    drain(40);

    // 6: random valid/ready traffic with distinct operands.
    n_iss = 0; n_cmp = 0; seq = 0;
    req_valid = '0; rsp_ready = '0;
    for (int c = 0; c < 1000; c++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!req_valid[i] || iss_seen[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          if (req_valid[i]) begin
            req_operand[i] = {4'(i), 56'(seq)};
            seq++;
          end
        end
      end
      rsp_ready = 4'($urandom_range(0, 15));
      tick();
    end
    drain(40);
    chk("t6_no_outstanding", outst, 0);
    chk("t6_issue_vs_complete", n_iss, n_cmp);
    chk("t6_some_traffic", n_iss > 100, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
